// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction prefetch front end.
package fetch_pkg;

    localparam int INST_BYTES = 4;

    // Occupancy/credit counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries; flush wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [31:0]              push_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [31:0]              head_inst,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
    } fetch_entry_t;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & ~flush & (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = '{pc: push_pc, inst: push_inst};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_pc   = mem_q[rd_ptr_q].pc;
    assign head_inst = mem_q[rd_ptr_q].inst;
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: credit-limited read issue, in-order response
// capture into a small queue, and redirect with drop of stale in-flight reads.
module inst_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              rd_ram_en,
    output logic [ADDR_W-1:0] rd_ram_addr,
    input  logic              rd_ram_gnt,
    input  logic              rd_ram_rvalid,
    input  logic [31:0]       rd_ram_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
);

    localparam int                CW        = cnt_width(DEPTH);
    localparam logic [CW:0]       DEPTH_L   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]     MAX_OUT_L = CW'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     q_count;
    logic              q_empty, q_push, q_pop;
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       head_inst;
    logic              credit, req_acc, rsp_ok;

    // Reserving a queue slot per in-flight read means a response can never overflow.
    always_comb begin
        credit = (outst_q < MAX_OUT_L) &&
                 (({1'b0, q_count} + {1'b0, outst_q}) < DEPTH_L);
    end

    assign rd_ram_en   = reset_n & fetch_en & ~redirect_valid & credit;
    assign rd_ram_addr = fetch_pc_q;
    assign req_acc     = rd_ram_en & rd_ram_gnt;
    assign rsp_ok      = rd_ram_rvalid & (outst_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(req_acc) - CW'(rsp_ok);
        drop_d     = drop_q;
        q_push     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = outst_q - CW'(rsp_ok);
        end else begin
            if (req_acc) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    q_push    = 1'b1;
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    assign q_pop = inst_valid & inst_ready & ~redirect_valid;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push),
        .push_pc   (resp_pc_q),
        .push_inst (rd_ram_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign inst_valid = ~q_empty;
    assign inst_data  = inst_valid ? head_inst : '0;
    assign inst_pc    = inst_valid ? head_pc : '0;
    assign busy       = (outst_q != '0);

    rvalid_without_request : assert property (
        @(posedge clk) disable iff (!reset_n) rd_ram_rvalid |-> (outst_q != '0)
    );

endmodule

// File: doc/inst_prefetch_unit.md
# inst_prefetch_unit

Parametrised instruction fetch front end that keeps a small queue of prefetched instructions ahead of decode. It sits between the execution unit's program-counter/decode logic and the instruction RAM read port. It adds three things over the single-shot two-stage fetch: a grant-based memory handshake, multiple outstanding reads, and a PC redirect that flushes stale work.

## Interface
Parameters:
- ADDR_W, 32: PC/address width.
- DEPTH, 4: prefetch queue entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unreturned reads; 1..DEPTH.
- RESET_PC, 0: PC loaded on reset.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- fetch_en  in  1  permit issuing new reads.
- redirect_valid  in  1  one-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; low 2 bits are zero.
- rd_ram_en  out  1  read request valid.
- rd_ram_addr  out  ADDR_W  read address.
- rd_ram_gnt  in  1  memory accepts the request this cycle.
- rd_ram_rvalid  in  1  read data valid; responses return in request order.
- rd_ram_data  in  32  read data.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  head instruction; 0 when inst_valid=0.
- inst_pc  out  ADDR_W  head PC; 0 when inst_valid=0.
- busy  out  1  outstanding read count ≠ 0.

## Operation
- Registered state:
  - fetch_pc: next request address.
  - resp_pc: PC of the next kept response.
  - outstanding count.
  - drop count.
  - queue.
- Credit rule:
  - rd_ram_en = fetch_en & ~redirect_valid & (outstanding < MAX_OUTSTANDING) & (occupancy + outstanding < DEPTH).
  - The credit rule guarantees every response has a free slot, so no overflow path exists.
- rd_ram_addr = fetch_pc.
- Request handshake:
  - Accepted request (rd_ram_en & rd_ram_gnt): fetch_pc += 4, outstanding += 1.
  - Without grant, rd_ram_addr holds. rd_ram_en drops without grant only on redirect, fetch_en=0, or no credit.
- Response, rd_ram_rvalid=1: outstanding -= 1.
  - If drop count > 0: discard the data, drop count -= 1.
  - Otherwise: push {resp_pc, rd_ram_data} and resp_pc += 4.
- Pop when inst_valid & inst_ready. Simultaneous push and pop are allowed at any occupancy.
- Redirect (redirect_valid=1):
  - fetch_pc and resp_pc load redirect_pc. Queue flushes.
  - drop count loads outstanding − rd_ram_rvalid. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. A pop in that cycle is ignored.
- Redirect while drops are pending: the drop count is reloaded per the rule above, which stays correct because outstanding covers all in-flight reads.
- rd_ram_rvalid with outstanding=0 is a protocol violation: ignored and flagged by an assertion.
- PC arithmetic wraps mod 2^ADDR_W. Counters are $clog2(DEPTH)+1 bits.

## Timing
- Reset (async assert, sync deassert is the system's responsibility):
  - fetch_pc = resp_pc = RESET_PC.
  - Counters 0, queue empty.
  - rd_ram_en=0 while reset_n=0. rd_ram_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0, busy=0.
- Reset mid-operation discards all state. Responses to pre-reset requests are the memory's responsibility (memory shares reset).
- rd_ram_en first rises in the first cycle after reset release with fetch_en=1.
- Latency:
  - Request granted in cycle N, memory latency L ≥ 1: response arrives in cycle N+L, inst_valid is seen in cycle N+L+1.
  - Redirect in cycle R: inst_valid=0 in R+1; the first new request is issued in R+1.
- Throughput is 1 instruction/cycle when MAX_OUTSTANDING ≥ L+1 and DEPTH ≥ MAX_OUTSTANDING+1.
- Full queue with inst_ready=0: requests stop, and outputs hold stable until popped.

## Structure
- Package fetch_pkg:
  - INST_BYTES=4.
  - typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] inst;}, parametrised via a package-level max width or a module-local typedef.
  - A helper function computing the count width.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, empty, and count.
  - Flush has priority over push and pop.
- The top level holds the PC/credit/drop logic.

## Test plan
- Reset release, fetch_en=1, L=1, inst_ready=1, MAX_OUTSTANDING=2 → addresses 0,4,8,… one per cycle; inst_pc 0,4,8 with matching data; first inst_valid at cycle 3 after release.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests are granted, rd_ram_en then stays 0; queue is full with PCs 0..12. Releasing inst_ready drains them in order and fetching resumes at 16.
- rd_ram_gnt held 0 for 3 cycles → rd_ram_en=1 with rd_ram_addr stable at 0, busy=0; on grant the address advances to 4.
- Redirect to 0x100 with 2 reads outstanding (L=3) → both stale responses dropped, queue empty next cycle; first delivered inst_pc=0x100 with data from 0x100.
- Redirect in the same cycle as a response, followed by a second redirect before drops finish → no stale instruction is ever delivered; PCs after the last redirect are sequential.
- Asynchronous reset asserted mid-burst → all outputs reach their reset values immediately; after release fetch restarts at RESET_PC.
